// File: rtl/imm_pack_pkg.sv
// Shared RISC-V immediate definitions: format selectors, error codes and the
// ext-to-instruction-bit packing used by imm_pack (and mirrored by extend).
package imm_pack_pkg;

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_B = 3'b010;
  localparam logic [2:0] SRC_J = 3'b011;
  localparam logic [2:0] SRC_U = 3'b100;

  typedef enum logic [1:0] {
    ERR_OK    = 2'b00,
    ERR_RANGE = 2'b01,
    ERR_ALIGN = 2'b10,
    ERR_SRC   = 2'b11
  } err_e;

  // Returns instruction bits [31:7]; imm bit k corresponds to instruction bit k+7.
  function automatic logic [24:0] pack_imm(input logic [31:0] ext, input logic [2:0] src);
    logic [24:0] p;
    p = '0;
    case (src)
      SRC_I: p[24:13] = ext[11:0];
      SRC_S: begin
        p[24:18] = ext[11:5];
        p[4:0]   = ext[4:0];
      end
      SRC_B: begin
        p[24]    = ext[12];
        p[23:18] = ext[10:5];
        p[4:1]   = ext[4:1];
        p[0]     = ext[11];
      end
      SRC_J: begin
        p[24]    = ext[20];
        p[23:14] = ext[10:1];
        p[13]    = ext[11];
        p[12:5]  = ext[19:12];
      end
      SRC_U:   p[24:5] = ext[31:12];
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/imm_pack_check.sv
// Combinational range/alignment checker for a sign-extended immediate.
module imm_check
  import imm_pack_pkg::*;
(
  input  logic [31:0] imm_ext,
  input  logic [2:0]  imm_src,
  output logic [1:0]  err
);

  logic w_fit12;
  logic w_fit13;
  logic w_fit21;

  // A value fits an N-bit signed field when every bit from N-1 upward matches.
  assign w_fit12 = (&imm_ext[31:11]) | ~(|imm_ext[31:11]);
  assign w_fit13 = (&imm_ext[31:12]) | ~(|imm_ext[31:12]);
  assign w_fit21 = (&imm_ext[31:20]) | ~(|imm_ext[31:20]);

  always_comb begin
    err = ERR_OK;
    case (imm_src)
      SRC_I, SRC_S: begin
        if (!w_fit12) err = ERR_RANGE;
      end
      SRC_B: begin
        if (imm_ext[0])    err = ERR_ALIGN;
        else if (!w_fit13) err = ERR_RANGE;
      end
      SRC_J: begin
        if (imm_ext[0])    err = ERR_ALIGN;
        else if (!w_fit21) err = ERR_RANGE;
      end
      SRC_U: begin
        if (|imm_ext[11:0]) err = ERR_RANGE;
      end
      default: err = ERR_SRC;
    endcase
  end

endmodule

// File: rtl/imm_pack.sv
// Two-stage immediate packer: stage 1 holds the request and checks it,
// stage 2 holds the packed bits and error code for a ready/valid consumer.
module imm_pack
  import imm_pack_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] imm_ext,
  input  logic [2:0]  imm_src,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] imm,
  output logic [1:0]  err,
  output logic [7:0]  err_cnt
);

  logic        r_s1_valid;
  logic [31:0] r_s1_ext;
  logic [2:0]  r_s1_src;
  logic        r_s2_valid;
  logic [24:0] r_imm;
  logic [1:0]  r_err;
  logic [7:0]  r_err_cnt;

  logic        w_s2_load;
  logic [1:0]  w_err;
  logic [24:0] w_imm;

  imm_check u_check (
    .imm_ext (r_s1_ext),
    .imm_src (r_s1_src),
    .err     (w_err)
  );

  assign w_s2_load = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_load;
  assign w_imm     = (w_err == ERR_OK) ? pack_imm(r_s1_ext, r_s1_src) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_ext   <= '0;
      r_s1_src   <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_ext <= imm_ext;
        r_s1_src <= imm_src;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_imm      <= '0;
      r_err      <= ERR_OK;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_imm <= w_imm;
        r_err <= w_err;
      end
    end
  end

  // Only the result departing s2 this cycle is counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (r_s2_valid && out_ready && (r_err != ERR_OK) && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign out_valid = r_s2_valid;
  assign imm       = r_imm;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: doc/imm_pack.md
IMM_PACK -- requirements
Module: imm_pack

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset; no parameters.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  request accepted when in_valid and in_ready are both high at a clk edge.
REQ-006 imm_ext  input  32  sign-extended immediate value to encode.
REQ-007 imm_src  input  3  format: 000 I, 001 S, 010 B, 011 J, 100 U; 101-111 are illegal.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer accepts the result when out_valid and out_ready are both high.
REQ-010 imm  output  25  packed instruction bits [31:7], in the exact layout consumed by extend.
REQ-011 err  output  2  00 ok, 01 out of range, 10 misaligned, 11 illegal imm_src.
REQ-012 err_cnt  output  8  saturating count of errored results delivered.

Function
REQ-013 Packing SHALL be the exact inverse of extend; every imm bit not named below SHALL be 0.
- I: imm[24:13] = imm_ext[11:0].
- S: imm[24:18] = imm_ext[11:5]; imm[4:0] = imm_ext[4:0].
- B: imm[24] = imm_ext[12]; imm[23:18] = imm_ext[10:5]; imm[4:1] = imm_ext[4:1]; imm[0] = imm_ext[11].
- J: imm[24] = imm_ext[20]; imm[23:14] = imm_ext[10:1]; imm[13] = imm_ext[11]; imm[12:5] = imm_ext[19:12].
- U: imm[24:5] = imm_ext[31:12].
REQ-014 Legal ranges SHALL be as follows; any value outside its range gives err = 01.
- I and S: -2048..2047.
- B: -4096..4094.
- J: -1048576..1048574.
- U: any value; a nonzero imm_ext[11:0] gives err = 01.
REQ-015 B or J with imm_ext[0] = 1 SHALL give err = 10.
REQ-016 Error priority SHALL be 11 > 10 > 01; when err != 00, imm SHALL be 0.
REQ-017 The datapath SHALL be a two-stage pipeline.
- Stage 1 registers imm_ext and imm_src, and performs the checks.
- Stage 2 registers imm and err.
- Latency from acceptance to out_valid is 2 cycles.
- Throughput is 1 result per cycle when out_ready stays high.
REQ-018 Stage advance rules:
- s2 loads when !s2_valid or out_ready.
- s1 advances when s2 loads.
- in_ready = !s1_valid or s1 advancing; this is a combinational path from out_ready.
REQ-019 While out_valid is high and out_ready is low, imm and err SHALL hold stable.
REQ-020 No request SHALL be dropped or duplicated under any in_valid/out_ready pattern.
REQ-021 err_cnt SHALL increment on each out_valid and out_ready handshake with err != 00, and SHALL saturate at 255.
REQ-022 A result leaving s2 and a new one entering s2 in the same cycle SHALL be legal; the count uses only the departing result.

Reset
REQ-023 On rst_n low, the block SHALL asynchronously clear s1_valid, s2_valid, imm, err and err_cnt to 0; out_valid is 0 and in_ready is 1.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight requests without producing output.
REQ-025 Reset deassertion SHALL take effect at the next clk edge; the first acceptance is possible at that edge.

Structure
REQ-026 The imm_src encodings and err codes SHALL be defined once in the shared RISC-V package, and extend SHALL use the same constants.
REQ-027 The range/alignment checker SHALL be the sub-module imm_check (combinational, imm_ext and imm_src in, err out), instantiated in stage 1.

Verification
REQ-028 The bench SHALL cover each of the following directed scenarios.
- I, -55 -> imm = 0x1F92000, err = 00, out_valid exactly 2 cycles after acceptance.
- J, 922000 -> imm = 0x0321C20, err = 00.
- U, 0x015A6000 -> imm = 0x002B4C0, err = 00; U, 0x015A6001 -> err = 01, imm = 0.
- B, 0x00000801 -> err = 10; B, 4096 -> err = 01; imm_src = 111 with any value -> err = 11; err_cnt = 3 afterwards.
- Hold out_ready low and offer 3 back-to-back requests -> 2 accepted, then in_ready = 0 and outputs held; release out_ready -> results delivered in order, with no loss.
- Pulse rst_n low with 2 requests in flight -> out_valid = 0 and err_cnt = 0 immediately, and no stale result after release.
- Round trip: feed imm through extend and check imm_ext is reproduced for 1000 random legal values per format.
